// File: rtl/ram_dump_if.sv
// Memory request port of the RAM dump engine: one outstanding read at a time,
// request held until grant, read data returned later on rvalid.
interface ram_dump_if;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ram_dump.sv
// Host-requested RAM readback: reads a byte range word by word and pushes it LSB-first into
// the UART TX FIFO. Define RAM_DUMP_CSUM_EN to append a mod-256 checksum byte after the data.
module ram_dump #(
    parameter logic [31:0] MEM_BASE  = 32'h0010_0000,
    parameter logic [31:0] MEM_BYTES = 32'h0001_0000
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        start_i,
    input  logic [31:0] addr_ini_i,
    input  logic [31:0] size_i,
    ram_dump_if.master  mem,
    input  logic        tx_full_i,
    output logic        tx_we_o,
    output logic [7:0]  tx_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StReq,
        StWaitRv,
        StSend,
        StFinish
    } state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_cur_addr, w_cur_addr_d;
    logic [31:0] r_bytes_left, w_bytes_left_d;
    logic [31:0] r_word_buf, w_word_buf_d;
    logic [32:0] w_end_excl;
    logic [32:0] w_ram_end;
    logic        w_range_bad;
    logic [7:0]  w_byte;

`ifdef RAM_DUMP_CSUM_EN
    logic [7:0]  r_csum, w_csum_d;
`endif

    // 33-bit end address exposes overflow of addr+size as bit 32.
    assign w_end_excl  = {1'b0, r_cur_addr} + {1'b0, r_bytes_left};
    assign w_ram_end   = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};
    assign w_range_bad = (r_cur_addr < MEM_BASE) || w_end_excl[32] || (w_end_excl > w_ram_end);
    assign w_byte      = r_word_buf[{r_cur_addr[1:0], 3'b000} +: 8];

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_state      <= StIdle;
            r_cur_addr   <= '0;
            r_bytes_left <= '0;
            r_word_buf   <= '0;
`ifdef RAM_DUMP_CSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_cur_addr   <= w_cur_addr_d;
            r_bytes_left <= w_bytes_left_d;
            r_word_buf   <= w_word_buf_d;
`ifdef RAM_DUMP_CSUM_EN
            r_csum       <= w_csum_d;
`endif
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_cur_addr_d   = r_cur_addr;
        w_bytes_left_d = r_bytes_left;
        w_word_buf_d   = r_word_buf;
`ifdef RAM_DUMP_CSUM_EN
        w_csum_d       = r_csum;
`endif
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_be     = 4'h0;
        mem.mem_addr   = '0;
        tx_we_o        = 1'b0;
        tx_data_o      = 8'h00;
        done_o         = 1'b0;
        err_o          = 1'b0;
        busy_o         = (r_state != StIdle);

        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_cur_addr_d   = addr_ini_i;
                    w_bytes_left_d = size_i;
`ifdef RAM_DUMP_CSUM_EN
                    w_csum_d       = 8'h00;
`endif
                    w_state_d      = StCheck;
                end
            end
            StCheck: begin
                if (r_bytes_left == 32'd0) begin
                    done_o    = 1'b1;
                    busy_o    = 1'b0;
                    w_state_d = StIdle;
                end else if (w_range_bad) begin
                    err_o     = 1'b1;
                    busy_o    = 1'b0;
                    w_state_d = StIdle;
                end else begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                mem.mem_req  = 1'b1;
                mem.mem_be   = 4'hF;
                mem.mem_addr = {r_cur_addr[31:2], 2'b00};
                if (mem.mem_gnt) begin
                    w_state_d = StWaitRv;
                end
            end
            StWaitRv: begin
                if (mem.mem_rvalid) begin
                    w_word_buf_d = mem.mem_rdata;
                    w_state_d    = StSend;
                end
            end
            StSend: begin
                tx_data_o = w_byte;
                if (!tx_full_i) begin
                    tx_we_o        = 1'b1;
                    w_cur_addr_d   = r_cur_addr + 32'd1;
                    w_bytes_left_d = r_bytes_left - 32'd1;
`ifdef RAM_DUMP_CSUM_EN
                    w_csum_d       = r_csum + w_byte;
`endif
                    // Decide on post-push values: last byte, or word exhausted.
                    if (r_bytes_left == 32'd1) begin
                        w_state_d = StFinish;
                    end else if (r_cur_addr[1:0] == 2'b11) begin
                        w_state_d = StReq;
                    end
                end
            end
            StFinish: begin
`ifdef RAM_DUMP_CSUM_EN
                tx_data_o = r_csum;
                if (!tx_full_i) begin
                    tx_we_o   = 1'b1;
                    done_o    = 1'b1;
                    busy_o    = 1'b0;
                    w_state_d = StIdle;
                end
`else
                done_o    = 1'b1;
                busy_o    = 1'b0;
                w_state_d = StIdle;
`endif
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_dump.sv
// Directed bench for ram_dump: memory responder with programmable grant/rvalid latency,
// TX FIFO backpressure generator and byte/pulse monitor.
module tb_ram_dump;
    localparam logic [31:0] Base = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr_ini = '0;
    logic [31:0] size = '0;
    logic        tx_full = 1'b0;
    logic        tx_we;
    logic [7:0]  tx_data;
    logic        busy, done, err;

    ram_dump_if mif ();

    ram_dump #(
        .MEM_BASE (Base),
        .MEM_BYTES(32'h0001_0000)
    ) dut (
        .clk_sys_i (clk),
        .rst_sys_ni(rst_n),
        .start_i   (start),
        .addr_ini_i(addr_ini),
        .size_i    (size),
        .mem       (mif),
        .tx_full_i (tx_full),
        .tx_we_o   (tx_we),
        .tx_data_o (tx_data),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  rxq[$];
    logic [31:0] rd_addrq[$];
    int          n_done = 0;
    int          n_err = 0;
    int          gnt_max = 0;
    int          rv_max = 1;
    bit          bp_rand = 1'b0;
    int          bp_hold = 0;
    logic [31:0] rsp_a;
    int          rsp_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM content model: byte at offset o from Base is (o+1)*17 mod 256,
    // so offsets 0..7 hold 11 22 33 44 55 66 77 88.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        logic [31:0] v;
        v = (a - Base + 32'd1) * 32'd17;
        return v[7:0];
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = ram_byte(a + 32'(j));
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_we) begin
                chk("tx_we_while_full", {31'd0, tx_full}, 32'd0);
                rxq.push_back(tx_data);
            end
            if (done) n_done++;
            if (err) n_err++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold > 0) begin
                tx_full = 1'b1;
                bp_hold--;
            end else if (bp_rand) begin
                tx_full = 1'($urandom_range(0, 1));
            end else begin
                tx_full = 1'b0;
            end
        end
    end

    initial begin
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mif.mem_req) begin
                rsp_a = mif.mem_addr;
                rsp_d = $urandom_range(0, gnt_max);
                repeat (rsp_d) begin
                    @(posedge clk);
                    #1;
                    chk("req_held", {31'd0, mif.mem_req}, 32'd1);
                    chk("addr_held", mif.mem_addr, rsp_a);
                end
                chk("mem_be", {28'd0, mif.mem_be}, 32'hF);
                chk("mem_we", {31'd0, mif.mem_we}, 32'd0);
                mif.mem_gnt = 1'b1;
                rd_addrq.push_back(rsp_a);
                @(posedge clk);
                #1;
                mif.mem_gnt = 1'b0;
                rsp_d = $urandom_range(1, rv_max);
                repeat (rsp_d - 1) begin
                    @(posedge clk);
                    #1;
                end
                mif.mem_rvalid = 1'b1;
                mif.mem_rdata  = ram_word(rsp_a);
                @(posedge clk);
                #1;
                mif.mem_rvalid = 1'b0;
                mif.mem_rdata  = '0;
            end
        end
    end

    task automatic run_dump(input string tag, input logic [31:0] a, input logic [31:0] s,
                            input int exp_reads, input bit exp_err);
        int         cyc;
        int         exp_len;
        int         nb;
        logic [7:0] sum;
        logic [31:0] w0;
        rxq.delete();
        rd_addrq.delete();
        n_done = 0;
        n_err  = 0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        addr_ini = a;
        size     = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (n_done == 0 && n_err == 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_finished"}, {31'd0, (cyc < 3000)}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, n_done, exp_err ? 32'd0 : 32'd1);
        chk({tag, "_err_cnt"}, n_err, exp_err ? 32'd1 : 32'd0);
        chk({tag, "_reads"}, rd_addrq.size(), exp_reads);
        w0 = {a[31:2], 2'b00};
        for (int i = 0; i < rd_addrq.size() && i < exp_reads; i++)
            chk({tag, "_rd_addr"}, rd_addrq[i], w0 + 32'(4 * i));
        nb = (exp_err || s == 0) ? 0 : int'(s);
        exp_len = nb;
`ifdef RAM_DUMP_CSUM_EN
        if (nb != 0) exp_len = nb + 1;
`endif
        chk({tag, "_len"}, rxq.size(), exp_len);
        sum = 8'h00;
        for (int i = 0; i < nb && i < rxq.size(); i++) begin
            chk({tag, "_byte"}, {24'd0, rxq[i]}, {24'd0, ram_byte(a + 32'(i))});
            sum = sum + ram_byte(a + 32'(i));
        end
`ifdef RAM_DUMP_CSUM_EN
        if (nb != 0 && rxq.size() > nb) chk({tag, "_csum"}, {24'd0, rxq[nb]}, {24'd0, sum});
`endif
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_tx_we", {31'd0, tx_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hand values: 11 22 33 44 55 66 77 88 over two aligned words.
        chk("model_w0", ram_word(Base), 32'h4433_2211);
        chk("model_w1", ram_word(Base + 32'd4), 32'h8877_6655);
        run_dump("aligned", Base, 32'd8, 2, 1'b0);
        run_dump("unaligned", Base + 32'd2, 32'd3, 2, 1'b0);

        gnt_max = 5;
        rv_max  = 4;
        run_dump("latency", Base + 32'd5, 32'd21, 6, 1'b0);

        rxq.delete();
        bp_rand = 1'b1;
        fork
            run_dump("backpressure", Base + 32'd1, 32'd30, 8, 1'b0);
            begin
                cyc = 0;
                while (rxq.size() < 2 && cyc < 500) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                chk("bp_reach_mid", {31'd0, (cyc < 500)}, 32'd1);
                bp_hold = 20;
                chk("bp_busy_mid", {31'd0, busy}, 32'd1);
                start    = 1'b1;
                addr_ini = 32'hFFFF_FFFF;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        bp_rand = 1'b0;
        gnt_max = 2;
        rv_max  = 2;

        run_dump("size0", Base, 32'd0, 0, 1'b0);
        run_dump("below_base", 32'h000F_FFFC, 32'd2, 0, 1'b1);
        run_dump("past_end", 32'h0010_FFFF, 32'd2, 0, 1'b1);
        run_dump("wrap", 32'hFFFF_FFFF, 32'd2, 0, 1'b1);

        rxq.delete();
        n_done = 0;
        n_err  = 0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        addr_ini = Base;
        size     = 32'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (rxq.size() < 3 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("rst_mid_reach3", {31'd0, (cyc < 500)}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx_we", {31'd0, tx_we}, 32'd0);
        chk("rst_mid_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_no_done", n_done, 32'd0);
        run_dump("after_rst", Base, 32'd8, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
